// File: rtl/input_channel_rc.sv
// Router input channel: flit FIFO, head-flit route lookup against the node table,
// and the wormhole/multicast request state machine toward the output mux controllers.
module input_channel_rc #(
  parameter int DATAW   = 32,
  parameter int IDW     = 4,
  parameter int DEPTH   = 4,
  parameter int LOCALID = 4
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   in_valid,
  input  logic [DATAW+1:0]       in_data,
  output logic                   in_ready,
  output logic [IDW-1:0]         dst_id,
  input  logic [2:0]             tbl_port,
  input  logic [1:0]             tbl_dstatus,
  output logic                   req,
  output logic [2:0]             port,
  output logic [1:0]             multab,
  input  logic [4:0]             grt,
  output logic [DATAW+1:0]       out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  logic [DATAW+1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [1:0]       state;
  logic [4:0]       pend, next_pend;
  logic [1:0]       head_type;
  logic             empty, push, pop, head_first, head_last;

  // dstatus 01 goes only to the local port, 11 goes to both forward and local.
  function automatic logic [4:0] route_mask(input logic [2:0] p, input logic [1:0] st);
    logic [4:0] m_fwd, m_loc;
    m_fwd = 5'b00001 << p;
    m_loc = 5'b00001 << LOCALID;
    case (st)
      2'b01:   return m_loc;
      2'b11:   return m_fwd | m_loc;
      default: return m_fwd;
    endcase
  endfunction

  assign out_data   = mem[rp];
  assign dst_id     = out_data[IDW-1:0];
  assign head_type  = out_data[DATAW+1:DATAW];
  assign head_first = head_type[0];
  assign head_last  = head_type[1];
  assign empty      = (count == '0);
  assign in_ready   = (count != (AW+1)'(DEPTH));
  assign push       = in_valid && in_ready;
  assign req        = (state == ACTIVE) && !empty && (pend != '0);
  assign next_pend  = pend & ~grt;

  always_comb begin
    pop = 1'b0;
    if (state == IDLE && !empty && !head_first) pop = 1'b1;
    if (req && next_pend == '0)                 pop = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wp     <= '0;
      rp     <= '0;
      count  <= '0;
      state  <= IDLE;
      pend   <= '0;
      port   <= '0;
      multab <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          // stray body/tail outside a packet is dropped and flagged
          if (!empty && head_first) state <= LOOKUP;
          else if (!empty)          err   <= 1'b1;
        end
        LOOKUP: begin
          port   <= (tbl_dstatus == 2'b01) ? 3'(LOCALID) : tbl_port;
          multab <= tbl_dstatus;
          pend   <= route_mask(tbl_port, tbl_dstatus);
          state  <= ACTIVE;
        end
        ACTIVE: begin
          if (req) begin
            if (next_pend == '0) begin
              if (head_last) begin
                state <= IDLE;
                pend  <= '0;
              end else begin
                pend  <= route_mask(port, multab);
              end
            end else begin
              pend <= next_pend;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_input_channel_rc.sv
// Directed bench for input_channel_rc: delivered flits are checked against a queue
// of expected flits filled as stimulus is pushed.
module tb_input_channel_rc;
  localparam int DATAW = 32;
  localparam int FW    = DATAW + 2;
  localparam logic [1:0] T_BODY = 2'b00, T_HEAD = 2'b01, T_TAIL = 2'b10, T_SINGLE = 2'b11;

  logic          clk = 1'b0;
  logic          rst_;
  logic          in_valid;
  logic [FW-1:0] in_data;
  logic          in_ready;
  logic [3:0]    dst_id;
  logic [2:0]    tbl_port;
  logic [1:0]    tbl_dstatus;
  logic          req;
  logic [2:0]    port;
  logic [1:0]    multab;
  logic [4:0]    grt;
  logic [FW-1:0] out_data;
  logic [2:0]    count;
  logic          err;

  int n_vec = 0;
  int n_bad = 0;
  logic [FW-1:0] sb[$];

  input_channel_rc #(.DATAW(DATAW), .IDW(4), .DEPTH(4), .LOCALID(4)) dut (
    .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dst_id(dst_id), .tbl_port(tbl_port), .tbl_dstatus(tbl_dstatus), .req(req),
    .port(port), .multab(multab), .grt(grt), .out_data(out_data), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [3:0] d, input logic [7:0] tag);
    return {t, 20'h0, tag, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [FW-1:0] f, input bit deliver);
    chk("in_ready_before_push", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = f;
    if (deliver) sb.push_back(f);
    step();
    in_valid = 1'b0;
  endtask

  task automatic grant(input logic [4:0] g, input bit pops);
    chk("req_at_grant", 64'(req), 64'd1);
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL scoreboard_empty: observed out_data %0h expected no pending flit", out_data);
    end else begin
      chk("out_data", 64'(out_data), 64'(sb[0]));
    end
    grt = g;
    step();
    grt = '0;
    if (pops && sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    rst_ = 1'b0; in_valid = 1'b0; in_data = '0;
    tbl_port = '0; tbl_dstatus = '0; grt = '0;
    step(); step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_port", 64'(port), 64'd0);
    chk("rst_multab", 64'(multab), 64'd0);
    rst_ = 1'b1;
    step();

    // single flit unicast, latency
    tbl_port = 3'd2; tbl_dstatus = 2'b00;
    push(mk(T_SINGLE, 4'd3, 8'h01), 1);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_req_c0", 64'(req), 64'd0);
    chk("t1_dst_id", 64'(dst_id), 64'd3);
    step();
    chk("t1_req_c1", 64'(req), 64'd0);
    step();
    chk("t1_req_c2", 64'(req), 64'd1);
    chk("t1_port", 64'(port), 64'd2);
    chk("t1_multab", 64'(multab), 64'd0);
    grant(5'b00100, 1);
    chk("t1_count_end", 64'(count), 64'd0);
    chk("t1_req_end", 64'(req), 64'd0);

    // 4-flit packet, fills FIFO then drains one per cycle
    tbl_port = 3'd1;
    push(mk(T_HEAD, 4'd1, 8'h20), 1);
    push(mk(T_BODY, 4'd1, 8'h21), 1);
    push(mk(T_BODY, 4'd1, 8'h22), 1);
    push(mk(T_TAIL, 4'd1, 8'h23), 1);
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    chk("t2_port", 64'(port), 64'd1);
    for (int i = 0; i < 4; i++) begin
      grant(5'b00010, 1);
      chk("t2_count_drain", 64'(count), 64'(3 - i));
      chk("t2_in_ready_drain", 64'(in_ready), 64'd1);
    end
    chk("t2_req_idle", 64'(req), 64'd0);

    // MULTABS, separate grants; a repeated forward grant must not pop
    tbl_port = 3'd0; tbl_dstatus = 2'b11;
    push(mk(T_SINGLE, 4'd5, 8'h30), 1);
    step(); step();
    chk("t3_port", 64'(port), 64'd0);
    chk("t3_multab", 64'(multab), 64'd3);
    grant(5'b00001, 0);
    chk("t3_count_half", 64'(count), 64'd1);
    grant(5'b00001, 0);
    chk("t3_count_regrant", 64'(count), 64'd1);
    grant(5'b10000, 1);
    chk("t3_count_done", 64'(count), 64'd0);
    chk("t3_req_done", 64'(req), 64'd0);

    // MULTABS, both grants together
    push(mk(T_SINGLE, 4'd5, 8'h31), 1);
    step(); step();
    grant(5'b10001, 1);
    chk("t3b_count", 64'(count), 64'd0);

    // MULTABS toward the local port itself: one grant suffices
    tbl_port = 3'd4; tbl_dstatus = 2'b11;
    push(mk(T_SINGLE, 4'd6, 8'h32), 1);
    step(); step();
    chk("t3c_port", 64'(port), 64'd4);
    grant(5'b10000, 1);
    chk("t3c_count", 64'(count), 64'd0);

    // absorb-only latches the local port regardless of table port
    tbl_port = 3'd2; tbl_dstatus = 2'b01;
    push(mk(T_SINGLE, 4'd7, 8'h33), 1);
    step(); step();
    chk("t3d_port", 64'(port), 64'd4);
    chk("t3d_multab", 64'(multab), 64'd1);
    grant(5'b10000, 1);
    chk("t3d_count", 64'(count), 64'd0);

    // 2-flit MULTABS packet: tail uses latched route, not the live table
    tbl_port = 3'd0; tbl_dstatus = 2'b11;
    push(mk(T_HEAD, 4'd5, 8'h40), 1);
    push(mk(T_TAIL, 4'd5, 8'h41), 1);
    step();
    tbl_port = 3'd3; tbl_dstatus = 2'b00;
    grant(5'b10001, 1);
    chk("t3e_count_head", 64'(count), 64'd1);
    grant(5'b00001, 0);
    chk("t3e_count_half", 64'(count), 64'd1);
    grant(5'b10000, 1);
    chk("t3e_count_done", 64'(count), 64'd0);
    chk("t3e_req_done", 64'(req), 64'd0);

    // mid-packet starvation
    tbl_port = 3'd3; tbl_dstatus = 2'b00;
    push(mk(T_HEAD, 4'd8, 8'h50), 1);
    push(mk(T_BODY, 4'd8, 8'h51), 1);
    step();
    chk("t4_port", 64'(port), 64'd3);
    tbl_port = 3'd0;
    grant(5'b01000, 1);
    grant(5'b01000, 1);
    chk("t4_count_empty", 64'(count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_req_starved", 64'(req), 64'd0);
      chk("t4_port_held", 64'(port), 64'd3);
      step();
    end
    push(mk(T_TAIL, 4'd8, 8'h52), 1);
    chk("t4_req_tail", 64'(req), 64'd1);
    grant(5'b01000, 1);
    chk("t4_count_end", 64'(count), 64'd0);
    chk("t4_req_end", 64'(req), 64'd0);

    // stray body in IDLE is dropped, err sticks
    push(mk(T_BODY, 4'd2, 8'h60), 0);
    chk("t5_count_stray", 64'(count), 64'd1);
    chk("t5_req_stray", 64'(req), 64'd0);
    step();
    chk("t5_count_drop", 64'(count), 64'd0);
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_req_drop", 64'(req), 64'd0);
    tbl_port = 3'd2; tbl_dstatus = 2'b00;
    push(mk(T_SINGLE, 4'd2, 8'h61), 1);
    step(); step();
    chk("t5_port", 64'(port), 64'd2);
    grant(5'b00100, 1);
    chk("t5_count_end", 64'(count), 64'd0);
    chk("t5_err_sticky", 64'(err), 64'd1);

    // full FIFO with simultaneous push/pop, then async reset mid-packet
    tbl_port = 3'd1;
    push(mk(T_HEAD, 4'd1, 8'h70), 1);
    push(mk(T_BODY, 4'd1, 8'h71), 1);
    push(mk(T_BODY, 4'd1, 8'h72), 1);
    push(mk(T_BODY, 4'd1, 8'h73), 1);
    chk("t6_count_full", 64'(count), 64'd4);
    chk("t6_in_ready_full", 64'(in_ready), 64'd0);
    chk("t6_req", 64'(req), 64'd1);
    chk("t6_out_head", 64'(out_data), 64'(sb[0]));
    in_valid = 1'b1;
    in_data  = mk(T_TAIL, 4'd1, 8'h74);
    grt      = 5'b00010;
    step();
    in_valid = 1'b0;
    grt      = '0;
    void'(sb.pop_front());
    chk("t6_count_refused", 64'(count), 64'd3);
    chk("t6_in_ready_after", 64'(in_ready), 64'd1);
    chk("t6_out_next", 64'(out_data), 64'(sb[0]));
    #2;
    rst_ = 1'b0;
    #1;
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_req", 64'(req), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd1);
    chk("t6_rst_port", 64'(port), 64'd0);
    sb.delete();
    step();
    rst_ = 1'b1;
    step();
    chk("t6_post_req", 64'(req), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
